// File: rtl/fifo_wr_arbiter_if.sv
// Requester beat bus plus FIFO write port shared by fifo_wr_arbiter.
// Ports: req_valid/last/data/ready per requester; fifo_full, fifo_wr_en, fifo_din.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_din;

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_wr_en,
    output fifo_din
  );

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet write arbiter in front of a single FIFO write port.
// Ports: clk, rst_n (sync, active low), bus (slave), busy, grant_id, pkt_done.
module fifo_wr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.slave    bus,
  output logic                busy,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                pkt_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic                pkt_q, pkt_d;

  logic                sel_valid;
  logic                sel_last;
  logic [WIDTH-1:0]    sel_data;
  logic [NUM_REQ-1:0]  others;
  logic                accept;
  logic                done;
  logic [ID_WIDTH:0]   pick_idle;
  logic [ID_WIDTH:0]   pick_next;

  // Returns {found, index}: first set bit of mask after ptr, wrapping.
  // Walking the distance downward lets the nearest hit win.
  function automatic logic [ID_WIDTH:0] rr_pick(
    input logic [ID_WIDTH-1:0] ptr,
    input logic [NUM_REQ-1:0]  mask
  );
    logic [ID_WIDTH:0]   r;
    logic [ID_WIDTH-1:0] idx;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (mask[idx]) begin
        r = {1'b1, idx};
      end
    end
    return r;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    others    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*WIDTH +: WIDTH];
      end else begin
        others[i] = bus.req_valid[i];
      end
    end
  end

  assign accept = (state_q == BUSY) && sel_valid
               && !bus.fifo_full;
  assign done   = accept && sel_last;

  // The holder's own valid belongs to the beat being
  // consumed, so it is masked out of the handover pick.
  assign pick_idle = rr_pick(last_q, bus.req_valid);
  assign pick_next = rr_pick(grant_q, others);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pkt_d   = done;
    unique case (state_q)
      IDLE: begin
        if (pick_idle[ID_WIDTH]) begin
          state_d = BUSY;
          grant_d = pick_idle[ID_WIDTH-1:0];
          last_d  = pick_idle[ID_WIDTH-1:0];
        end
      end
      BUSY: begin
        if (done) begin
          last_d = grant_q;
          if (pick_next[ID_WIDTH]) begin
            grant_d = pick_next[ID_WIDTH-1:0];
            last_d  = pick_next[ID_WIDTH-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wr_en = accept;
    bus.fifo_din   = sel_data;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == BUSY && grant_q == ID_WIDTH'(i)) begin
        bus.req_ready[i] = !bus.fifo_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      pkt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign grant_id = grant_q;
  assign pkt_done = pkt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
// Ports: drives bus (master side), clk, rst_n; checks busy/grant_id/pkt_done.
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  logic       pkt_done;

  fifo_wr_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

  fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_done (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic        busy;
    logic [1:0]  grant;
    logic [3:0]  ready;
    logic        wr;
    logic [7:0]  din;
    logic        pkt;
  } vec_t;

  vec_t vt[$];

  int rem[4], plen[4], bidx[4], cnt[4];
  logic [7:0] wr_log[$];
  logic [7:0] fq[$];
  logic [7:0] drained[$];

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; plen[i] = 1; bidx[i] = 0; cnt[i] = 0;
    end
  endtask

  // One clock of the requester model; samples outputs before the edge.
  task automatic drive_cycle(input logic full_in, input logic rst_in);
    logic [3:0]  v, l;
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v[i] = rem[i] > 0;
      l[i] = bidx[i] == plen[i] - 1;
      d[i*8 +: 8] = 8'(i * 16 + cnt[i]);
    end
    rst_n         = rst_in;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.fifo_full = full_in;
    #1;
    if (bus.fifo_wr_en) wr_log.push_back(bus.fifo_din);
    for (int i = 0; i < 4; i++) begin
      if (v[i] && bus.req_ready[i]) begin
        cnt[i]++;
        rem[i]--;
        bidx[i] = (bidx[i] + 1) % plen[i];
      end
    end
  endtask

  task automatic do_reset();
    clear_reqs();
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0);
    wr_log.delete();
  endtask

  initial begin
    int rdy_low, wr_low, stall, drop_err;
    logic saw_full;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // reset state, with requests present during reset
    repeat (2) @(negedge clk);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst grant", grant_id, 0);
    chk("rst pkt_done", pkt_done, 0);
    chk("rst ready", bus.req_ready, 0);
    chk("rst wr_en", bus.fifo_wr_en, 0);

    // req2 3-beat, reset, req1 4-beat with req0 contending then 1-beat
    vt.push_back('{1, 4'b0100, 4'b0000, 32'h00A1_0000, 0, 0, 0, 4'b0000, 0, 8'h00, 0});
    vt.push_back('{1, 4'b0100, 4'b0000, 32'h00A1_0000, 0, 1, 2, 4'b0100, 1, 8'hA1, 0});
    vt.push_back('{1, 4'b0100, 4'b0000, 32'h00A2_0000, 0, 1, 2, 4'b0100, 1, 8'hA2, 0});
    vt.push_back('{1, 4'b0100, 4'b0100, 32'h00A3_0000, 0, 1, 2, 4'b0100, 1, 8'hA3, 0});
    vt.push_back('{1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 0, 8'h00, 1});
    vt.push_back('{1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 0, 8'h00, 0});
    vt.push_back('{0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 0, 8'h00, 0});
    vt.push_back('{1, 4'b0010, 4'b0000, 32'h0000_B100, 0, 0, 0, 4'b0000, 0, 8'h00, 0});
    vt.push_back('{1, 4'b0010, 4'b0000, 32'h0000_B100, 0, 1, 1, 4'b0010, 1, 8'hB1, 0});
    vt.push_back('{1, 4'b0011, 4'b0000, 32'h0000_B2C1, 0, 1, 1, 4'b0010, 1, 8'hB2, 0});
    vt.push_back('{1, 4'b0011, 4'b0000, 32'h0000_B3C1, 0, 1, 1, 4'b0010, 1, 8'hB3, 0});
    vt.push_back('{1, 4'b0011, 4'b0010, 32'h0000_B4C1, 0, 1, 1, 4'b0010, 1, 8'hB4, 0});
    vt.push_back('{1, 4'b0001, 4'b0001, 32'h0000_00C1, 0, 1, 0, 4'b0001, 1, 8'hC1, 1});
    vt.push_back('{1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 0, 8'h00, 1});
    vt.push_back('{1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 4'b0000, 0, 8'h00, 0});

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      rst_n         = vt[k].rst_n;
      bus.req_valid = vt[k].valid;
      bus.req_last  = vt[k].last;
      bus.req_data  = vt[k].data;
      bus.fifo_full = vt[k].full;
      #1;
      chk($sformatf("v%0d busy", k), busy, vt[k].busy);
      chk($sformatf("v%0d ready", k), bus.req_ready, vt[k].ready);
      chk($sformatf("v%0d wr_en", k), bus.fifo_wr_en, vt[k].wr);
      chk($sformatf("v%0d pkt_done", k), pkt_done, vt[k].pkt);
      if (vt[k].busy) chk($sformatf("v%0d grant", k), grant_id, vt[k].grant);
      if (vt[k].wr) chk($sformatf("v%0d din", k), bus.fifo_din, vt[k].din);
    end

    // round robin: all valid, 2-beat packets, back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 4; plen[i] = 2;
    end
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b0, 1'b1);
      if (c >= 1 && c <= 10) chk($sformatf("rr wr_en c%0d", c), bus.fifo_wr_en, 1);
      if (c % 2 == 1 && c <= 9) chk($sformatf("rr grant c%0d", c), grant_id, ((c - 1) / 2) % 4);
    end
    chk("rr writes", (wr_log.size() >= 10) ? 1 : 0, 1);
    for (int k = 0; k < 10 && k < wr_log.size(); k++) begin
      chk($sformatf("rr data %0d", k), wr_log[k],
          ((k / 2) % 4) * 16 + (k / 8) * 2 + k % 2);
    end

    // backpressure on req3 beat 2 for 3 cycles
    do_reset();
    rem[3] = 4; plen[3] = 4;
    rdy_low = 0; wr_low = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle((c >= 2 && c <= 4), 1'b1);
      if (busy && !bus.req_ready[3]) rdy_low++;
      if (busy && !bus.fifo_wr_en) wr_low++;
      if (c == 8) chk("bp pkt_done", pkt_done, 1);
    end
    chk("bp ready low cycles", rdy_low, 3);
    chk("bp wr_en low cycles", wr_low, 3);
    chk("bp beat count", wr_log.size(), 4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      chk($sformatf("bp data %0d", k), wr_log[k], 8'h30 + k);
    end

    // reset during beat 2 of req1
    do_reset();
    rem[1] = 4; plen[1] = 4;
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
    clear_reqs();
    rem[1] = 4; plen[1] = 4;
    rem[3] = 2; plen[3] = 2;
    drive_cycle(1'b0, 1'b1);
    chk("mr busy", busy, 0);
    chk("mr ready", bus.req_ready, 0);
    chk("mr wr_en", bus.fifo_wr_en, 0);
    chk("mr pkt_done", pkt_done, 0);
    drive_cycle(1'b0, 1'b1);
    chk("mr regrant busy", busy, 1);
    chk("mr regrant id", grant_id, 1);

    // 20 beats into a 16-deep FIFO model, then drain
    do_reset();
    fq.delete();
    drained.delete();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 5; plen[i] = 5;
    end
    stall = 0; drop_err = 0; saw_full = 1'b0;
    for (int c = 0; c < 60 && stall < 3; c++) begin
      logic f;
      f = fq.size() >= 16;
      drive_cycle(f, 1'b1);
      if (bus.fifo_wr_en) begin
        if (f) drop_err++;
        fq.push_back(bus.fifo_din);
      end
      if (f) begin
        saw_full = 1'b1;
        if (!bus.fifo_wr_en) stall++;
      end
    end
    chk("ff saw full", saw_full, 1);
    chk("ff fill level", fq.size(), 16);
    for (int c = 0; c < 80 && drained.size() < 20; c++) begin
      logic f;
      f = fq.size() >= 16;
      drive_cycle(f, 1'b1);
      if (fq.size() > 0) drained.push_back(fq.pop_front());
      if (bus.fifo_wr_en) begin
        if (f) drop_err++;
        fq.push_back(bus.fifo_din);
      end
    end
    chk("ff drained count", drained.size(), 20);
    chk("ff write while full", drop_err, 0);
    for (int k = 0; k < 20 && k < drained.size(); k++) begin
      chk($sformatf("ff data %0d", k), drained[k], (k / 5) * 16 + k % 5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares a single `fifo` instance among `NUM_REQ` packet-producing requesters. It accepts valid/ready beats from each requester, locks the grant to one requester for a whole packet (terminated by `req_last`), and drives the FIFO write port (`fifo_wr_en`, `fifo_din`) while honouring `fifo_full`. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `WIDTH`, 8: data width per beat, equal to the FIFO `WIDTH`.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of the grant index.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req_valid`  input  NUM_REQ  per-requester beat valid.
- `req_last`  input  NUM_REQ  per-requester last beat of packet, qualified by `req_valid`.
- `req_data`  input  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  output  NUM_REQ  per-requester beat accepted this cycle when high with `req_valid`.
- `fifo_full`  input  1  FIFO full flag.
- `fifo_wr_en`  output  1  FIFO write enable.
- `fifo_din`  output  WIDTH  FIFO write data.
- `busy`  output  1  high while a packet grant is held.
- `grant_id`  output  ID_WIDTH  index of the current grant holder; valid while `busy`.
- `pkt_done`  output  1  one-cycle pulse on acceptance of a `req_last` beat.

## Operation
- States: IDLE, BUSY. `busy` = (state == BUSY).
- Registered state: state, `grant_id`, round-robin pointer `last_id`, `pkt_done`.
- Arbitration: winner = first i with `req_valid[i]`, searching (last_id+1) mod NUM_REQ upward and wrapping. `req_last` does not affect arbitration.
- IDLE: if any `req_valid` is high, load `grant_id` and `last_id` with the winner and go to BUSY. No beat is accepted in IDLE.
- BUSY:
  - `req_ready[grant_id]` = !fifo_full; all other `req_ready` bits are 0.
  - `fifo_wr_en` = req_valid[grant_id] && !fifo_full.
  - `fifo_din` = req_data[grant_id]. When `fifo_wr_en` is 0, `fifo_din` is don't-care but is still driven from the mux.
  - Accepted beat = `fifo_wr_en`. The arbiter adds no storage; it transfers one beat per cycle.
  - Accepted beat with `req_last[grant_id]`:
    - Set `pkt_done` high next cycle.
    - Re-arbitrate in the same cycle, with the pointer set to the current `grant_id`.
    - If any `req_valid` is high (excluding the current holder's in-flight beat, which uses the old pointer), load the new winner and stay BUSY. This gives back-to-back packets with no bubble. The same requester can win again only if no other requester is valid.
    - Otherwise go to IDLE.
  - The grant never changes mid-packet, whatever the other requests do.
  - A deasserted `req_valid[grant_id]` mid-packet holds the grant; there is no timeout.
- Requester contract: once `req_valid` is high it stays high with stable data until `req_ready`. The arbiter does not check this.
- Combinational paths: `req_valid`/`req_data`/`fifo_full` to `fifo_wr_en`/`fifo_din`/`req_ready`. `fifo_full` is a registered compare inside the FIFO, so there is no loop.

## Timing
- Reset (`rst_n` low at a rising edge), applied next cycle:
  - state = IDLE, `busy` = 0, `grant_id` = 0.
  - `last_id` = NUM_REQ-1, so requester 0 has first priority.
  - `pkt_done` = 0, `req_ready` = 0, `fifo_wr_en` = 0.
- Reset mid-packet abandons the packet. The partial packet already written stays in the FIFO; the FIFO's own reset is separate.
- Latency:
  - From `req_valid` rising in IDLE to the first beat accepted: 1 cycle (grant cycle), first write on cycle 2.
  - Between packets while another requester is pending: 0 cycles.
- `fifo_full` high during BUSY stalls with `req_ready` = 0 and `fifo_wr_en` = 0. Transfer resumes the cycle `fifo_full` drops.
- A single-beat packet (`req_last` on the first beat) is legal and completes in 1 BUSY cycle.
- `pkt_done` asserts the cycle after the last beat and lasts 1 cycle, including on consecutive packets.

## Test plan
- Reset then single requester: req 2 sends a 3-beat packet 0xA1,0xA2,0xA3 with last on the 3rd -> `grant_id`=2 after 1 cycle; FIFO gets the 3 writes on consecutive cycles; `pkt_done` pulses once; return to IDLE.
- All 4 requesters valid continuously with 2-beat packets from reset -> grant order 0,1,2,3,0; no idle cycle between packets; each packet's beats are contiguous in the FIFO.
- Contention mid-packet: req 1 is granted with a 4-beat packet and req 0 asserts at beat 2 -> req 1 finishes all 4 beats, then req 0 is granted with 0 bubble.
- Backpressure: `fifo_full` forced high for 3 cycles in beat 2 of req 3's packet -> `req_ready[3]` and `fifo_wr_en` are low for exactly 3 cycles; no beat is lost or duplicated; data order is preserved.
- Reset mid-packet: `rst_n` low during beat 2 of req 1's packet -> next cycle `busy`=0 and `req_ready`=0; after release with req 1 and req 3 valid, req 0 has priority, so the first grant is 1.
- Integrated with `fifo` (DEPTH 16): 20 beats queued across requesters -> the FIFO fills to 16, `fifo_full` stalls the writer, and reads drain the data in arbitrated order with no drops.
